// File: rtl/piso_shift_pkg.sv
// Shared FSM state encoding and counter sizing for the piso_shift_tx serializer.
package piso_shift_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Bit counter width: ceil(log2(width)), never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register; serial bit is taken straight from the end register bit.
// Latency: loaded word's first bit is visible the cycle after load; load wins over shift.
module piso_shift_reg
  import piso_shift_pkg::*;
#(
  parameter int W         = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_dat_i,
  input  logic         shift_i,
  output logic         sout_o
);

  logic [W-1:0] sr_q, sr_d;

  // Zeros are shifted in so the register is empty (SOUT=0) once a frame drains.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_dat_i;
    end else if (shift_i) begin
      sr_d = MSB_FIRST ? {sr_q[W-2:0], 1'b0} : {1'b0, sr_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sout_o = MSB_FIRST ? sr_q[W-1] : sr_q[0];

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter; optional even parity bit with PISO_SHIFT_TX_PARITY_EN.
// Latency: first bit one cycle after accept; LOAD_READY only in IDLE or on the last bit (no gap).
module piso_shift_tx
  import piso_shift_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] D,
  output logic             SOUT,
  output logic             SVALID,
  output logic             SLAST,
  output logic             BUSY
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam int FRAME_W = WIDTH + 1;
`else
  localparam int FRAME_W = WIDTH;
`endif

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                svalid_q, svalid_d;
  logic                slast_q, slast_d;
  logic                busy_q, busy_d;
  logic                accept;
  logic [FRAME_W-1:0]  frame_dat;

  // Parity rides in the shift register as the final bit of the frame.
`ifdef PISO_SHIFT_TX_PARITY_EN
  assign frame_dat = MSB_FIRST ? {D, ^D} : {^D, D};
`else
  assign frame_dat = D;
`endif

  assign LOAD_READY = (state_q == IDLE) || (svalid_q && slast_q);
  assign accept     = LOAD_VALID && LOAD_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slast_d = slast_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = CNT_INIT;
      slast_d = 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == '0) begin
`ifdef PISO_SHIFT_TX_PARITY_EN
            state_d = PARITY;
            slast_d = 1'b1;
`else
            state_d = IDLE;
            slast_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q - CNT_ONE;
`ifdef PISO_SHIFT_TX_PARITY_EN
            slast_d = 1'b0;
`else
            slast_d = (cnt_q == CNT_ONE);
`endif
          end
        end
`ifdef PISO_SHIFT_TX_PARITY_EN
        PARITY: begin
          state_d = IDLE;
          slast_d = 1'b0;
        end
`endif
        default: begin
          state_d = IDLE;
          slast_d = 1'b0;
        end
      endcase
    end
    svalid_d = (state_d != IDLE);
    busy_d   = svalid_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      svalid_q <= 1'b0;
      slast_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      svalid_q <= svalid_d;
      slast_q  <= slast_d;
      busy_q   <= busy_d;
    end
  end

  piso_shift_reg #(
    .W         (FRAME_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load_i     (accept),
    .load_dat_i (frame_dat),
    .shift_i    (svalid_q),
    .sout_o     (SOUT)
  );

  assign SVALID = svalid_q;
  assign SLAST  = slast_q;
  assign BUSY   = busy_q;

endmodule
